arm_exec_mem_unit: RTL and testbench
====================================

Name: arm_exec_mem_unit

Overview:
Execute/memory slice of the single-cycle ARM CPU, built around three pieces of logic.
- A 64-bit ALU with status flags and a flag register.
- Two 64-bit adders for next-PC calculation (PC+4 and PC+branch offset).
- A byte-addressed data memory addressed by the ALU result.
- The control unit drives it; the register file feeds operands; the PC register consumes next_pc.

Parameters:
DATA_BYTES, 1024, data memory size in bytes (power of 2, ≥8)
ADDR_W, 64, address/data width (fixed at 64; not overridable)

Ports:
clk  in  1  single clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; clears flag register
a  in  64  ALU operand A (Da)
b  in  64  ALU operand B (already muxed Db/Imm12/D9)
cntrl  in  3  ALU operation select
setflags  in  1  latch ALU flags into flag register at clock edge
mem_we  in  1  data memory write enable
mem_re  in  1  data memory read enable
wdata  in  64  store data (Db)
xfer_size  in  4  bytes per access: 1,2,4,8
pc  in  64  current PC
br_offset  in  64  sign-extended branch word offset (not yet shifted)
branch  in  1  select branch target for next_pc
alu_result  out  64  ALU result (also memory address)
negative, zero, overflow, carry_out  out  1 each  combinational ALU flags
neg_reg, zero_reg, ovf_reg, carry_reg  out  1 each  registered flags
rdata  out  64  load data
pc_plus4  out  64  pc + 4
br_target  out  64  pc + (br_offset << 2)
next_pc  out  64  branch ? br_target : pc_plus4

Behaviour:
- ALU is combinational, 64-bit two's complement:
  - 000 pass B
  - 010 A+B
  - 011 A−B (A + ~B + 1)
  - 100 A&B
  - 101 A|B
  - 110 A^B
  - 001 and 111 give result 0.
- Flags:
  - negative = result[63]; zero = (result == 0).
  - carry_out = carry out of bit 63 for add/sub (sub carry = no borrow); 0 for other ops.
  - overflow = signed overflow for add/sub; 0 otherwise.
- Flag register:
  - reset low asynchronously clears all four to 0.
  - On a rising clk edge with setflags=1, captures the current combinational flags; otherwise holds.
  - Reset has priority over setflags.
- Adders: pure combinational 64-bit, wrap modulo 2^64, no carry output. Branch shift discards the top 2 bits of br_offset.
- Data memory:
  - Byte-addressed, little-endian. Address = alu_result modulo DATA_BYTES.
  - Access must be aligned to xfer_size; simulation assertion on misalignment, on non-power-of-2 xfer_size, and on mem_we & mem_re both high.
  - Write: on rising clk with mem_we=1, stores the low xfer_size bytes of wdata.
  - Read: combinational. With mem_re=1, rdata = xfer_size bytes zero-extended; with mem_re=0, rdata = 0.
  - A read of an address written in the same cycle returns the old data until the edge.
  - Contents are not cleared by reset and are undefined until written.
- Reset values:
  - Registered flags are 0.
  - All other outputs are combinational functions of the inputs/memory and are unaffected by reset.

Decomposition:
- Shared package arm_cpu_pkg:
  - alu_op_t enum (PASS_B=3'b000, ADD=3'b010, SUB=3'b011, AND=3'b100, OR=3'b101, XOR=3'b110).
  - Constant PC_INCR=64'd4.
- Natural sub-module: arm_alu64 (combinational ALU + flags). Adders, flag register and memory stay inline.

Test Plan:
- Flag reset and hold: reset low mid-cycle with setflags=1 → all *_reg go 0 immediately. Release reset with setflags=0, apply SUB 5−5 → zero=1 combinational but zero_reg stays 0.
- ALU arithmetic: ADD 0x7FFF_FFFF_FFFF_FFFF+1 → result 0x8000_0000_0000_0000, negative=1, overflow=1, carry_out=0. SUB 3−5 → 0xFFFF_FFFF_FFFF_FFFE, negative=1, carry_out=0. SUB 5−3 → 2, carry_out=1.
- Flag latching: setflags=1 on SUB 3−5, clock → neg_reg=1. Next cycle setflags=0 with ADD 1+1 → neg_reg still 1.
- Logic ops: A=0xF0F0, B=0x0FF0 → AND 0x00F0, OR 0xFFF0, XOR 0xFF00, PASS_B 0x0FF0, cntrl=111 → 0 with zero=1.
- Memory: mem_we, xfer 8, addr 16, wdata 0x1122_3344_5566_7788, clock. Then mem_re, xfer 8 → rdata 0x1122_3344_5566_7788. xfer 1 at addr 16 → 0x88. mem_re=0 → 0.
- Next-PC: pc=0x100, br_offset=−3 (0xFFFF_FFFF_FFFF_FFFD) → pc_plus4=0x104, br_target=0xF4. branch=1 → next_pc=0xF4; branch=0 → 0x104.

Source files
------------

// File: rtl/arm_cpu_pkg.sv
// Shared types and constants for the single-cycle ARM CPU datapath.
package arm_cpu_pkg;

  localparam int ADDR_W = 64;
  localparam logic [63:0] PC_INCR = 64'd4;

  typedef enum logic [2:0] {
    PASS_B = 3'b000,
    ADD    = 3'b010,
    SUB    = 3'b011,
    AND    = 3'b100,
    OR     = 3'b101,
    XOR    = 3'b110
  } alu_op_t;

  // Legal memory transfer sizes are 1, 2, 4 or 8 bytes.
  function automatic logic is_pow2_size(input logic [3:0] size);
    return (size == 4'd1) || (size == 4'd2) || (size == 4'd4) || (size == 4'd8);
  endfunction

endpackage

// File: rtl/arm_alu64.sv
// 64-bit combinational ALU with negative/zero/overflow/carry flags.
module arm_alu64
  import arm_cpu_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [2:0]  cntrl,
  output logic [63:0] result,
  output logic        negative,
  output logic        zero,
  output logic        overflow,
  output logic        carry_out
);

  logic        is_sub_s;
  logic [63:0] opb_s;
  logic [64:0] sum_s;

  // Shared adder: subtraction is A + ~B + 1, so carry means "no borrow".
  always_comb begin
    is_sub_s = (cntrl == SUB);
    opb_s    = is_sub_s ? ~b : b;
    sum_s    = {1'b0, a} + {1'b0, opb_s} + {64'd0, is_sub_s};
  end

  // Operation select and flag generation.
  always_comb begin
    result    = 64'd0;
    overflow  = 1'b0;
    carry_out = 1'b0;
    case (cntrl)
      PASS_B: result = b;
      ADD, SUB: begin
        result    = sum_s[63:0];
        carry_out = sum_s[64];
        overflow  = (a[63] == opb_s[63]) && (sum_s[63] != a[63]);
      end
      AND:     result = a & b;
      OR:      result = a | b;
      XOR:     result = a ^ b;
      default: result = 64'd0;
    endcase
    negative = result[63];
    zero     = (result == 64'd0);
  end

endmodule

// File: rtl/arm_exec_mem_unit_chk.sv
// Protocol checks on data-memory accesses: legal size, alignment, no simultaneous read/write.
module arm_exec_mem_unit_chk
  import arm_cpu_pkg::*;
(
  input logic       clk,
  input logic       reset,
  input logic       mem_we,
  input logic       mem_re,
  input logic [3:0] xfer_size,
  input logic [2:0] addr_low
);

  a_size_legal: assert property (@(posedge clk) disable iff (!reset)
    (mem_we || mem_re) |-> is_pow2_size(xfer_size));

  a_aligned: assert property (@(posedge clk) disable iff (!reset)
    (mem_we || mem_re) |-> ((addr_low & 3'(xfer_size - 4'd1)) == 3'd0));

  a_no_rw_collision: assert property (@(posedge clk) disable iff (!reset)
    !(mem_we && mem_re));

endmodule

// File: rtl/arm_exec_mem_unit.sv
// Execute/memory slice: ALU + flag register, next-PC adders, byte-addressed data memory.
module arm_exec_mem_unit
  import arm_cpu_pkg::*;
#(
  parameter int DATA_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [2:0]  cntrl,
  input  logic        setflags,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [63:0] wdata,
  input  logic [3:0]  xfer_size,
  input  logic [63:0] pc,
  input  logic [63:0] br_offset,
  input  logic        branch,
  output logic [63:0] alu_result,
  output logic        negative,
  output logic        zero,
  output logic        overflow,
  output logic        carry_out,
  output logic        neg_reg,
  output logic        zero_reg,
  output logic        ovf_reg,
  output logic        carry_reg,
  output logic [63:0] rdata,
  output logic [63:0] pc_plus4,
  output logic [63:0] br_target,
  output logic [63:0] next_pc
);

  localparam int AW = $clog2(DATA_BYTES);

  logic [7:0]    mem_r [DATA_BYTES];
  logic [AW-1:0] addr_s;
  logic [63:0]   rdata_s;

  arm_alu64 u_alu (
    .a         (a),
    .b         (b),
    .cntrl     (cntrl),
    .result    (alu_result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  // Flag register; reset wins over setflags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      neg_reg   <= 1'b0;
      zero_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      carry_reg <= 1'b0;
    end else if (setflags) begin
      neg_reg   <= negative;
      zero_reg  <= zero;
      ovf_reg   <= overflow;
      carry_reg <= carry_out;
    end
  end

  // Next-PC adders; the word-offset shift drops the top two offset bits.
  always_comb begin
    pc_plus4  = pc + PC_INCR;
    br_target = pc + {br_offset[61:0], 2'b00};
    next_pc   = branch ? br_target : pc_plus4;
  end

  assign addr_s = alu_result[AW-1:0];

  // Little-endian byte writes; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < xfer_size) begin
          mem_r[addr_s + AW'(i)] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Combinational read, zero-extended to 64 bits.
  always_comb begin
    rdata_s = 64'd0;
    if (mem_re) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < xfer_size) begin
          rdata_s[8*i +: 8] = mem_r[addr_s + AW'(i)];
        end else begin
          rdata_s[8*i +: 8] = 8'd0;
        end
      end
    end else begin
      rdata_s = 64'd0;
    end
  end

  assign rdata = rdata_s;

  arm_exec_mem_unit_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .xfer_size (xfer_size),
    .addr_low  (alu_result[2:0])
  );

endmodule

// File: tb/tb_arm_exec_mem_unit.sv
// Scoreboard bench for arm_exec_mem_unit: expectations queued at drive time, checked at sample time.
module tb_arm_exec_mem_unit;

  localparam int SEL_RES = 0, SEL_NEG = 1, SEL_ZERO = 2, SEL_OVF = 3, SEL_CARRY = 4,
                 SEL_NEGR = 5, SEL_ZEROR = 6, SEL_OVFR = 7, SEL_CARRYR = 8,
                 SEL_RDATA = 9, SEL_PC4 = 10, SEL_BRT = 11, SEL_NPC = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] a = 64'd0, b = 64'd0, wdata = 64'd0, pc = 64'd0, br_offset = 64'd0;
  logic [2:0]  cntrl = 3'd0;
  logic        setflags = 1'b0, mem_we = 1'b0, mem_re = 1'b0, branch = 1'b0;
  logic [3:0]  xfer_size = 4'd8;
  logic [63:0] alu_result, rdata, pc_plus4, br_target, next_pc;
  logic        negative, zero, overflow, carry_out;
  logic        neg_reg, zero_reg, ovf_reg, carry_reg;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   err_cnt = 0;
  int   chk_cnt = 0;

  always #5 clk = ~clk;

  arm_exec_mem_unit #(.DATA_BYTES(1024)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .cntrl(cntrl), .setflags(setflags),
    .mem_we(mem_we), .mem_re(mem_re), .wdata(wdata), .xfer_size(xfer_size),
    .pc(pc), .br_offset(br_offset), .branch(branch),
    .alu_result(alu_result), .negative(negative), .zero(zero), .overflow(overflow),
    .carry_out(carry_out), .neg_reg(neg_reg), .zero_reg(zero_reg), .ovf_reg(ovf_reg),
    .carry_reg(carry_reg), .rdata(rdata), .pc_plus4(pc_plus4), .br_target(br_target),
    .next_pc(next_pc)
  );

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      SEL_RES:    return alu_result;
      SEL_NEG:    return {63'd0, negative};
      SEL_ZERO:   return {63'd0, zero};
      SEL_OVF:    return {63'd0, overflow};
      SEL_CARRY:  return {63'd0, carry_out};
      SEL_NEGR:   return {63'd0, neg_reg};
      SEL_ZEROR:  return {63'd0, zero_reg};
      SEL_OVFR:   return {63'd0, ovf_reg};
      SEL_CARRYR: return {63'd0, carry_reg};
      SEL_RDATA:  return rdata;
      SEL_PC4:    return pc_plus4;
      SEL_BRT:    return br_target;
      SEL_NPC:    return next_pc;
      default:    return 64'hDEAD_DEAD_DEAD_DEAD;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic alu(input logic [2:0] op, input logic [63:0] av, input logic [63:0] bv);
    cntrl = op;
    a     = av;
    b     = bv;
  endtask

  initial begin
    // Reset state of the flag register
    expect_val("rst_neg", SEL_NEGR, 64'd0);
    expect_val("rst_zero", SEL_ZEROR, 64'd0);
    expect_val("rst_ovf", SEL_OVFR, 64'd0);
    expect_val("rst_carry", SEL_CARRYR, 64'd0);
    tick();

    // Latch flags, then assert reset mid-cycle with setflags still high
    reset = 1'b1;
    alu(3'b011, 64'd3, 64'd5);
    setflags = 1'b1;
    expect_val("pre_rst_negreg", SEL_NEGR, 64'd1);
    tick();
    #2;
    reset = 1'b0;
    expect_val("async_rst_neg", SEL_NEGR, 64'd0);
    expect_val("async_rst_carry", SEL_CARRYR, 64'd0);
    settle();

    // Release with setflags low: combinational zero only
    reset = 1'b1;
    setflags = 1'b0;
    alu(3'b011, 64'd5, 64'd5);
    expect_val("sub55_zero", SEL_ZERO, 64'd1);
    settle();
    expect_val("sub55_zeroreg_hold", SEL_ZEROR, 64'd0);
    tick();

    // Arithmetic
    alu(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    expect_val("add_ovf_res", SEL_RES, 64'h8000_0000_0000_0000);
    expect_val("add_ovf_neg", SEL_NEG, 64'd1);
    expect_val("add_ovf_ovf", SEL_OVF, 64'd1);
    expect_val("add_ovf_carry", SEL_CARRY, 64'd0);
    settle();
    alu(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    expect_val("add_wrap_res", SEL_RES, 64'd0);
    expect_val("add_wrap_carry", SEL_CARRY, 64'd1);
    expect_val("add_wrap_zero", SEL_ZERO, 64'd1);
    settle();
    alu(3'b011, 64'd3, 64'd5);
    expect_val("sub35_res", SEL_RES, 64'hFFFF_FFFF_FFFF_FFFE);
    expect_val("sub35_neg", SEL_NEG, 64'd1);
    expect_val("sub35_carry", SEL_CARRY, 64'd0);
    expect_val("sub35_ovf", SEL_OVF, 64'd0);
    settle();
    alu(3'b011, 64'd5, 64'd3);
    expect_val("sub53_res", SEL_RES, 64'd2);
    expect_val("sub53_carry", SEL_CARRY, 64'd1);
    settle();
    alu(3'b011, 64'h8000_0000_0000_0000, 64'd1);
    expect_val("sub_ovf_ovf", SEL_OVF, 64'd1);
    expect_val("sub_ovf_res", SEL_RES, 64'h7FFF_FFFF_FFFF_FFFF);
    settle();

    // Flag latching and hold
    alu(3'b011, 64'd3, 64'd5);
    setflags = 1'b1;
    expect_val("latch_negreg", SEL_NEGR, 64'd1);
    expect_val("latch_carryreg", SEL_CARRYR, 64'd0);
    tick();
    setflags = 1'b0;
    alu(3'b010, 64'd1, 64'd1);
    expect_val("hold_negreg", SEL_NEGR, 64'd1);
    tick();
    setflags = 1'b1;
    alu(3'b011, 64'd5, 64'd3);
    expect_val("latch2_negreg", SEL_NEGR, 64'd0);
    expect_val("latch2_carryreg", SEL_CARRYR, 64'd1);
    tick();
    alu(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    expect_val("latch3_ovfreg", SEL_OVFR, 64'd1);
    tick();
    setflags = 1'b0;

    // Logic ops
    alu(3'b100, 64'hF0F0, 64'h0FF0);
    expect_val("and", SEL_RES, 64'h00F0);
    settle();
    alu(3'b101, 64'hF0F0, 64'h0FF0);
    expect_val("or", SEL_RES, 64'hFFF0);
    expect_val("or_carry", SEL_CARRY, 64'd0);
    settle();
    alu(3'b110, 64'hF0F0, 64'h0FF0);
    expect_val("xor", SEL_RES, 64'hFF00);
    settle();
    alu(3'b000, 64'hF0F0, 64'h0FF0);
    expect_val("pass_b", SEL_RES, 64'h0FF0);
    settle();
    alu(3'b111, 64'hF0F0, 64'h0FF0);
    expect_val("op111_res", SEL_RES, 64'd0);
    expect_val("op111_zero", SEL_ZERO, 64'd1);
    settle();
    alu(3'b001, 64'hF0F0, 64'h0FF0);
    expect_val("op001_res", SEL_RES, 64'd0);
    settle();

    // Memory: 8-byte store then sized loads
    alu(3'b000, 64'd0, 64'd16);
    xfer_size = 4'd8;
    wdata = 64'h1122_3344_5566_7788;
    mem_we = 1'b1;
    tick();
    mem_we = 1'b0;
    mem_re = 1'b1;
    expect_val("ld8", SEL_RDATA, 64'h1122_3344_5566_7788);
    settle();
    xfer_size = 4'd1;
    expect_val("ld1", SEL_RDATA, 64'h88);
    settle();
    alu(3'b000, 64'd0, 64'd18);
    xfer_size = 4'd2;
    expect_val("ld2", SEL_RDATA, 64'h5566);
    settle();
    alu(3'b000, 64'd0, 64'd20);
    xfer_size = 4'd4;
    expect_val("ld4", SEL_RDATA, 64'h1122_3344);
    settle();
    alu(3'b000, 64'd0, 64'd1040);
    xfer_size = 4'd8;
    expect_val("ld_wrap", SEL_RDATA, 64'h1122_3344_5566_7788);
    settle();
    mem_re = 1'b0;
    expect_val("ld_off", SEL_RDATA, 64'd0);
    settle();

    // Byte store only touches one byte; read back sees old data until the edge
    alu(3'b000, 64'd0, 64'd17);
    xfer_size = 4'd1;
    wdata = 64'hFFFF_FFFF_FFFF_FFAB;
    mem_we = 1'b1;
    tick();
    mem_we = 1'b0;
    mem_re = 1'b1;
    alu(3'b000, 64'd0, 64'd16);
    xfer_size = 4'd8;
    expect_val("st1_merge", SEL_RDATA, 64'h1122_3344_5566_AB88);
    settle();
    mem_re = 1'b0;

    // Next-PC
    pc = 64'h100;
    br_offset = 64'hFFFF_FFFF_FFFF_FFFD;
    branch = 1'b1;
    expect_val("pc_plus4", SEL_PC4, 64'h104);
    expect_val("br_target", SEL_BRT, 64'hF4);
    expect_val("next_pc_br", SEL_NPC, 64'hF4);
    settle();
    branch = 1'b0;
    expect_val("next_pc_seq", SEL_NPC, 64'h104);
    settle();
    pc = 64'hFFFF_FFFF_FFFF_FFFC;
    br_offset = 64'h4000_0000_0000_0001;
    expect_val("pc4_wrap", SEL_PC4, 64'd0);
    expect_val("brt_shift_drop", SEL_BRT, 64'd0);
    settle();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
